// File: rtl/alu_exec_unit.sv
// Single-cycle RISC-V integer execute stage: ALU control decode, 32-bit ALU and one output register stage.
// Optional build macro ALU_XOR_EN enables funct3=100 decode to XOR (ALU code 100).
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             op_5,
  input  logic             funct7_5,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid
);

  localparam logic [2:0] CTL_ADD = 3'b000;
  localparam logic [2:0] CTL_SUB = 3'b001;
  localparam logic [2:0] CTL_AND = 3'b010;
  localparam logic [2:0] CTL_OR  = 3'b011;
  localparam logic [2:0] CTL_XOR = 3'b100;
  localparam logic [2:0] CTL_SLT = 3'b101;

  logic [WIDTH-1:0] alu_y;
  logic             slt_lt;

  always_comb begin
    alu_control = CTL_ADD;
    case (alu_op)
      2'b00: alu_control = CTL_ADD;
      2'b01: alu_control = CTL_SUB;
      2'b10: begin
        case (funct3)
          // Only R-type (op_5=1) honours funct7_5; ADDI with funct7_5=1 stays add.
          3'b000:  alu_control = (op_5 & funct7_5) ? CTL_SUB : CTL_ADD;
          3'b010:  alu_control = CTL_SLT;
          3'b110:  alu_control = CTL_OR;
          3'b111:  alu_control = CTL_AND;
`ifdef ALU_XOR_EN
          3'b100:  alu_control = CTL_XOR;
`endif
          default: alu_control = CTL_ADD;
        endcase
      end
      default: alu_control = CTL_ADD;
    endcase
  end

  assign slt_lt = $signed(src_a) < $signed(src_b);

  always_comb begin
    alu_y = '0;
    case (alu_control)
      CTL_ADD: alu_y = src_a + src_b;
      CTL_SUB: alu_y = src_a - src_b;
      CTL_AND: alu_y = src_a & src_b;
      CTL_OR:  alu_y = src_a | src_b;
`ifdef ALU_XOR_EN
      CTL_XOR: alu_y = src_a ^ src_b;
`else
      CTL_XOR: alu_y = '0;
`endif
      CTL_SLT: alu_y = {{(WIDTH-1){1'b0}}, slt_lt};
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= alu_y;
        zero   <= (alu_y == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; honours ALU_XOR_EN for the funct3=100 slot.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        op_5;
  logic        funct7_5;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  alu_control;
  logic [31:0] result;
  logic        zero;
  logic        out_valid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        op5;
    logic        f75;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_5        (op_5),
    .funct7_5    (funct7_5),
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control),
    .result      (result),
    .zero        (zero),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive(input vec_t v, input logic vld);
    alu_op   = v.op;
    funct3   = v.f3;
    op_5     = v.op5;
    funct7_5 = v.f75;
    src_a    = v.a;
    src_b    = v.b;
    in_valid = vld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t v;
    reset = 1'b1;
    v = '{2'b00, 3'b000, 1'b0, 1'b0, 32'h11, 32'h22, 32'h0};
    drive(v, 1'b1);
    step();
    step();
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want %h", result, 32'h0); end
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_decoder();
    logic [9:0] dv [13];
    logic [2:0] exp_ctl;
    // {alu_op, funct3, op_5, funct7_5, expected alu_control}
    dv[0]  = {2'b00, 3'b010, 1'b1, 1'b1, 3'b000};
    dv[1]  = {2'b01, 3'b000, 1'b0, 1'b0, 3'b001};
    dv[2]  = {2'b01, 3'b111, 1'b1, 1'b1, 3'b001};
    dv[3]  = {2'b10, 3'b000, 1'b0, 1'b0, 3'b000};
    dv[4]  = {2'b10, 3'b000, 1'b1, 1'b0, 3'b000};
    dv[5]  = {2'b10, 3'b000, 1'b1, 1'b1, 3'b001};
    dv[6]  = {2'b10, 3'b000, 1'b0, 1'b1, 3'b000};
    dv[7]  = {2'b10, 3'b010, 1'b0, 1'b0, 3'b101};
    dv[8]  = {2'b10, 3'b110, 1'b1, 1'b0, 3'b011};
    dv[9]  = {2'b10, 3'b111, 1'b1, 1'b0, 3'b010};
    dv[10] = {2'b10, 3'b001, 1'b1, 1'b1, 3'b000};
    dv[11] = {2'b10, 3'b101, 1'b1, 1'b1, 3'b000};
    dv[12] = {2'b11, 3'b111, 1'b1, 1'b1, 3'b000};
    in_valid = 1'b0;
    for (int i = 0; i < 13; i++) begin
      alu_op   = dv[i][9:8];
      funct3   = dv[i][7:5];
      op_5     = dv[i][4];
      funct7_5 = dv[i][3];
      #1;
      checks++;
      if (alu_control !== dv[i][2:0]) begin
        errors++;
        $display("FAIL decode[%0d]: alu_control got %b want %b", i, alu_control, dv[i][2:0]);
      end
    end
    alu_op = 2'b10; funct3 = 3'b100; op_5 = 1'b1; funct7_5 = 1'b0;
`ifdef ALU_XOR_EN
    exp_ctl = 3'b100;
`else
    exp_ctl = 3'b000;
`endif
    #1;
    checks++;
    if (alu_control !== exp_ctl) begin
      errors++;
      $display("FAIL decode_funct3_100: alu_control got %b want %b", alu_control, exp_ctl);
    end
  endtask

  task automatic run_vectors(input string name, input vec_t v);
    drive(v, 1'b1);
    step();
    checks++;
    if (result !== v.y) begin errors++; $display("FAIL %s_result: got %h want %h", name, result, v.y); end
    checks++;
    if (zero !== (v.y == 32'h0)) begin errors++; $display("FAIL %s_zero: got %b want %b", name, zero, (v.y == 32'h0)); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid: got %b want 1", name, out_valid); end
  endtask

  task automatic test_add_sub();
    vec_t v [7];
    v[0] = '{2'b00, 3'b000, 1'b0, 1'b0, 32'h00000010, 32'h00000020, 32'h00000030};
    v[1] = '{2'b00, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    v[2] = '{2'b00, 3'b000, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000};
    v[3] = '{2'b01, 3'b000, 1'b0, 1'b0, 32'h00000050, 32'h00000020, 32'h00000030};
    v[4] = '{2'b01, 3'b000, 1'b0, 1'b0, 32'h00000020, 32'h00000020, 32'h00000000};
    v[5] = '{2'b01, 3'b000, 1'b0, 1'b0, 32'h00000010, 32'h00000020, 32'hFFFFFFF0};
    v[6] = '{2'b10, 3'b000, 1'b1, 1'b1, 32'h00000050, 32'h00000020, 32'h00000030};
    for (int i = 0; i < 7; i++) run_vectors($sformatf("addsub%0d", i), v[i]);
  endtask

  task automatic test_logic();
    vec_t v [4];
    v[0] = '{2'b10, 3'b111, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0000FFFF};
    v[1] = '{2'b10, 3'b111, 1'b1, 1'b0, 32'hAAAAAAAA, 32'h55555555, 32'h00000000};
    v[2] = '{2'b10, 3'b110, 1'b1, 1'b0, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF};
    v[3] = '{2'b10, 3'b110, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 4; i++) run_vectors($sformatf("logic%0d", i), v[i]);
  endtask

  task automatic test_slt();
    vec_t v [4];
    v[0] = '{2'b10, 3'b010, 1'b1, 1'b0, 32'h00000010, 32'h00000020, 32'h00000001};
    v[1] = '{2'b10, 3'b010, 1'b1, 1'b0, 32'h00000020, 32'h00000010, 32'h00000000};
    v[2] = '{2'b10, 3'b010, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    v[3] = '{2'b10, 3'b010, 1'b1, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};
    for (int i = 0; i < 4; i++) run_vectors($sformatf("slt%0d", i), v[i]);
  endtask

  task automatic test_xor_slot();
    vec_t v;
`ifdef ALU_XOR_EN
    v = '{2'b10, 3'b100, 1'b1, 1'b0, 32'h12345678, 32'h87654321, 32'h95511559};
`else
    // Without the XOR build, funct3=100 decodes to add.
    v = '{2'b10, 3'b100, 1'b1, 1'b0, 32'h12345678, 32'h87654321, 32'h99999999};
`endif
    run_vectors("funct3_100", v);
  endtask

  task automatic test_back_to_back();
    vec_t v [3];
    v[0] = '{2'b00, 3'b000, 1'b0, 1'b0, 32'h00000001, 32'h00000002, 32'h00000003};
    v[1] = '{2'b01, 3'b000, 1'b0, 1'b0, 32'h00000009, 32'h00000004, 32'h00000005};
    v[2] = '{2'b10, 3'b110, 1'b1, 1'b0, 32'h000000F0, 32'h0000000F, 32'h000000FF};
    for (int i = 0; i < 3; i++) run_vectors($sformatf("b2b%0d", i), v[i]);
  endtask

  task automatic test_hold();
    vec_t v;
    v = '{2'b00, 3'b000, 1'b0, 1'b0, 32'h00001000, 32'h00000234, 32'h00001234};
    run_vectors("hold_load", v);
    v = '{2'b01, 3'b000, 1'b0, 1'b0, 32'h00000007, 32'h00000007, 32'h0};
    drive(v, 1'b0);
    step();
    step();
    checks++;
    if (result !== 32'h00001234) begin errors++; $display("FAIL hold_result: got %h want %h", result, 32'h00001234); end
    checks++;
    if (zero !== 1'b0) begin errors++; $display("FAIL hold_zero: got %b want 0", zero); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    vec_t v;
    v = '{2'b00, 3'b000, 1'b0, 1'b0, 32'h0000ABCD, 32'h00000001, 32'h0000ABCE};
    run_vectors("areset_pre", v);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL areset_result: got %h want %h", result, 32'h0); end
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL areset_zero: got %b want 1", zero); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
    step();
    checks++;
    if (result !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_held: got result=%h out_valid=%b want 0/0", result, out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    v = '{2'b01, 3'b000, 1'b0, 1'b0, 32'h00000100, 32'h00000001, 32'h000000FF};
    run_vectors("areset_first", v);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct3 = 3'b000;
    op_5 = 1'b0; funct7_5 = 1'b0; src_a = '0; src_b = '0;
    test_reset();
    test_decoder();
    test_add_sub();
    test_logic();
    test_slt();
    test_xor_slot();
    test_back_to_back();
    test_hold();
    test_async_reset();
    in_valid = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
